// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface muldiv_unit_if #(
   parameter int DATA_W = 32
);
   logic              start;
   logic [2:0]        op;
   logic              flush;
   logic [DATA_W-1:0] data1;
   logic [DATA_W-1:0] data2;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] hi;
   logic [DATA_W-1:0] lo;

   modport master (
      output start, op, flush, data1, data2,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, flush, data1, data2,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One shift-add or restoring-divide step per cycle, sign fix-up at the end.
module muldiv_unit #(
   parameter int DATA_W = 32
) (
   input logic         clk,
   input logic         rst,
   muldiv_unit_if.slave bus
);
   localparam int CW = $clog2(DATA_W);
   localparam int W  = DATA_W;

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t          state;
   state_t          state_nx;
   logic [CW-1:0]   count;
   logic [2*W-1:0]  acc;
   logic [W-1:0]    opb;
   logic [W-1:0]    hi_q;
   logic [W-1:0]    lo_q;
   logic            is_div;
   logic            sign_q;
   logic            sign_r;
   logic            dz;
   logic            done_q;
   logic            busy;

   logic op_mul, op_div, op_sgn, op_mthi, op_mtlo;
   logic accept;

   always_comb begin
      op_mul  = 1'b0;
      op_div  = 1'b0;
      op_sgn  = 1'b0;
      op_mthi = 1'b0;
      op_mtlo = 1'b0;
      unique case (bus.op)
         3'b001: begin op_mul = 1'b1; op_sgn = 1'b1; end
         3'b010: op_mul = 1'b1;
         3'b011: begin op_div = 1'b1; op_sgn = 1'b1; end
         3'b100: op_div = 1'b1;
         3'b101: op_mthi = 1'b1;
         3'b110: op_mtlo = 1'b1;
         default: ;
      endcase
   end

   assign accept = bus.start && !bus.flush && (state == IDLE);

   // Magnitudes wrap mod 2^W, so the most negative value maps to itself.
   logic s1, s2;
   logic [W-1:0] a_mag, b_mag;
   assign s1    = op_sgn & bus.data1[W-1];
   assign s2    = op_sgn & bus.data2[W-1];
   assign a_mag = s1 ? -bus.data1 : bus.data1;
   assign b_mag = s2 ? -bus.data2 : bus.data2;

   // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
   logic [W:0]     mul_sum;
   logic [W:0]     div_sh;
   logic [W+1:0]   div_diff;
   logic [2*W-1:0] iter;

   always_comb begin
      mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opb} : '0);
      div_sh   = {acc[2*W-1:W], acc[W-1]};
      div_diff = {1'b0, div_sh} - {2'b00, opb};
      if (!is_div)
         iter = {mul_sum, acc[W-1:1]};
      else if (div_diff[W+1])
         iter = {div_sh[W-1:0], acc[W-2:0], 1'b0};
      else
         iter = {div_diff[W-1:0], acc[W-2:0], 1'b1};
   end

   logic unused_bits;
   assign unused_bits = ^{div_sh[W], div_diff[W]};

   logic [2*W-1:0] prod_fix;
   logic [W-1:0]   quo_fix;
   logic [W-1:0]   rem_fix;

   // A zero divisor leaves the quotient at all ones regardless of sign.
   always_comb begin
      prod_fix = sign_q ? -acc : acc;
      quo_fix  = (sign_q && !dz) ? -acc[W-1:0] : acc[W-1:0];
      rem_fix  = sign_r ? -acc[2*W-1:W] : acc[2*W-1:W];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (accept && (op_mul || op_div)) state_nx = CALC;
         CALC: begin
            if (bus.flush)                     state_nx = IDLE;
            else if (count == CW'(W - 1))      state_nx = FIX;
         end
         FIX:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count  <= '0;
         acc    <= '0;
         opb    <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         is_div <= 1'b0;
         sign_q <= 1'b0;
         sign_r <= 1'b0;
         dz     <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            IDLE: if (accept) begin
               if (op_mthi) hi_q <= bus.data1;
               if (op_mtlo) lo_q <= bus.data1;
               if (op_mul || op_div) begin
                  acc    <= {{W{1'b0}}, op_div ? a_mag : b_mag};
                  opb    <= op_div ? b_mag : a_mag;
                  count  <= '0;
                  is_div <= op_div;
                  sign_q <= s1 ^ s2;
                  sign_r <= s1;
                  dz     <= op_div && (bus.data2 == '0);
               end
            end
            CALC: if (!bus.flush) begin
               acc   <= iter;
               count <= count + 1'b1;
            end
            FIX: if (!bus.flush) begin
               if (is_div) begin
                  lo_q <= quo_fix;
                  hi_q <= rem_fix;
               end else begin
                  lo_q <= prod_fix[W-1:0];
                  hi_q <= prod_fix[2*W-1:W];
               end
               done_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy = busy;
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the EX stage.
- Sits beside the ALU and shares the same data1/data2 operand buses.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Its hi/lo outputs feed the EX result mux for MFHI/MFLO, and its busy output drives the pipeline stall logic.

Parameters:
DATA_W, 32, operand/HI/LO width. Cycle counts below are stated for 32 and scale as DATA_W+1.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  one-cycle request; op/data1/data2 sampled on the same edge
op  input  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (treated as none)
flush  input  1  abort the in-flight operation (exception/branch squash)
data1  input  DATA_W  rs operand (multiplicand / dividend / MTHI/MTLO source)
data2  input  DATA_W  rt operand (multiplier / divisor)
busy  output  1  operation in progress; stall consumers of hi/lo
done  output  1  one-cycle pulse: HI/LO were updated by a mult/div on the last edge
hi  output  DATA_W  HI register
lo  output  DATA_W  LO register

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=IDLE; hi=0, lo=0, busy=0, done=0.
  - Iteration counter and work registers cleared.
- States: IDLE, CALC, FIX. busy = (state != IDLE), decoded from registered state.
- IDLE, start=1, flush=0:
  - MTHI: hi<=data1 on that edge. MTLO: lo<=data1 on that edge. State stays IDLE; no busy, no done.
  - MULT/MULTU/DIV/DIVU: latch the operand magnitudes. For signed ops use |x| computed modulo 2^32, so 0x80000000 stays 0x80000000. For unsigned ops use the raw value.
  - Also latch sign_q = s1^s2 and sign_r = s1; both are 0 for unsigned ops.
  - Enter CALC with count=0.
  - op none/reserved: no effect.
- CALC: one iteration per edge, count increments; at count==31 go to FIX.
  - Multiply: radix-2 shift-add on a 64-bit accumulator.
  - Divide: restoring, one quotient bit per cycle; 33-bit partial remainder.
- FIX (one cycle). On its closing edge:
  - Apply two's-complement negation: the 64-bit product if sign_q; the quotient if sign_q; the remainder if sign_r.
  - Multiply writes hi<=product[63:32], lo<=product[31:0]. Divide writes lo<=quotient, hi<=remainder.
  - state<=IDLE, done<=1 for exactly one cycle.
- Latency: start edge E0; busy high for cycles E0..E33 (33 cycles); hi/lo and done valid after edge E33. A new start is accepted on the cycle done is high.
- start while busy: ignored entirely, including MTHI/MTLO. The pipeline must stall, not retry.
- flush:
  - In CALC/FIX: next edge returns to IDLE, hi/lo unchanged, done stays 0.
  - flush with start in the same IDLE cycle: flush wins, nothing is executed.
  - flush in IDLE: no effect.
- Divide by zero (signed or unsigned): completes in normal latency with lo=0xFFFFFFFF, hi=data1 as latched. No exception.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No exception.
- Remainder takes the dividend's sign. Quotient truncates toward zero.
- hi/lo are held stable throughout CALC/FIX; intermediate values never appear on the outputs.

Test Plan:
- MULT data1=0xFFFFFFFD (-3), data2=5 -> after 33 busy cycles, done=1; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then MULT on the same operands -> hi=0, lo=1.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100/7 -> lo=14, hi=2.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 5/0 -> lo=0xFFFFFFFF, hi=5.
- Start MULTU 3x4, then:
  - pulse start with MTLO 0x55 at cycle 10 -> ignored;
  - flush at cycle 20 -> busy low next cycle, no done, hi/lo retain prior values;
  - MTHI 0xABCD in IDLE -> hi=0xABCD after one edge, busy never asserted.
- Assert rst asynchronously mid-CALC of a DIV -> busy, done, hi, lo all 0 immediately without a clock edge. After release, a MULT 6x7 gives lo=42, hi=0.
